// File: rtl/active_list.sv
// active_list: in-order retirement buffer that sits downstream of the rename
// map table. It allocates one renamed instruction per cycle at the tail and
// records writeback completion out of order. It retires the head entry in
// program order and hands the previous physical register back to the free list.
module active_list #(
  parameter int DEPTH  = 16,
  parameter int PREG_W = 6,
  parameter int LREG_W = 5,
  parameter int TAG_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic              alloc_uses_rw,
  input  logic [LREG_W-1:0] alloc_logical,
  input  logic [PREG_W-1:0] alloc_prev_phys,
  input  logic [PREG_W-1:0] alloc_new_phys,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              wb_valid,
  input  logic [TAG_W-1:0]  wb_tag,
  input  logic              flush,
  output logic              commit_valid,
  output logic [PREG_W-1:0] commit_reg_addr,
  output logic [LREG_W-1:0] commit_logical,
  output logic [PREG_W-1:0] commit_new_phys,
  output logic [TAG_W:0]    count,
  output logic              empty,
  output logic              full
);

  localparam int CNT_W = TAG_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Per-entry control bits. These are reset.
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] done_q,  done_d;

  // Per-entry payload. This is only read when the matching valid bit is set.
  logic              uses_rw_mem [DEPTH];
  logic [LREG_W-1:0] logical_mem [DEPTH];
  logic [PREG_W-1:0] prev_mem    [DEPTH];
  logic [PREG_W-1:0] new_mem     [DEPTH];

  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic              commit_valid_q, commit_valid_d;
  logic [PREG_W-1:0] commit_addr_q,  commit_addr_d;
  logic [LREG_W-1:0] commit_lreg_q,  commit_lreg_d;
  logic [PREG_W-1:0] commit_new_q,   commit_new_d;

  logic alloc_fire;
  logic retire_fire;

  // Status outputs are decoded from registered state only. A retire in this
  // cycle does not make room for an allocation in the same cycle.
  assign full        = (count_q == FULL_CNT);
  assign empty       = (count_q == '0);
  assign alloc_ready = !full;
  assign alloc_tag   = tail_q;
  assign count       = count_q;

  assign commit_valid    = commit_valid_q;
  assign commit_reg_addr = commit_addr_q;
  assign commit_logical  = commit_lreg_q;
  assign commit_new_phys = commit_new_q;

  // Flush overrides every other event in the cycle. Retire looks at the done
  // bit from before the edge, so a writeback to the head retires one cycle later.
  assign alloc_fire  = alloc_valid && !full && !flush;
  assign retire_fire = valid_q[head_q] && done_q[head_q] && !flush;

  // Next-state logic for the pointers, the count, the control bits and the commit port.
  always_comb begin
    // NOTE: every variable gets a default first, so no path through this
    // block leaves a signal unassigned and no latch can be inferred.
    valid_d        = valid_q;
    done_d         = done_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    commit_valid_d = 1'b0;
    commit_addr_d  = commit_addr_q;
    commit_lreg_d  = commit_lreg_q;
    commit_new_d   = commit_new_q;

    if (flush) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wb_valid && valid_q[wb_tag]) begin
        done_d[wb_tag] = 1'b1;
      end
      if (retire_fire) begin
        valid_d[head_q] = 1'b0;
        done_d[head_q]  = 1'b0;
        head_d          = head_q + 1'b1;
        commit_valid_d  = uses_rw_mem[head_q];
        commit_addr_d   = prev_mem[head_q];
        commit_lreg_d   = logical_mem[head_q];
        commit_new_d    = new_mem[head_q];
      end
      // The tail entry is never valid when an allocation fires, so a
      // writeback to that slot in the same cycle cannot conflict with it.
      if (alloc_fire) begin
        valid_d[tail_q] = 1'b1;
        done_d[tail_q]  = 1'b0;
        tail_d          = tail_q + 1'b1;
      end
      count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(retire_fire);
    end
  end

  // Control state and commit port registers, with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q        <= '0;
      done_q         <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_addr_q  <= '0;
      commit_lreg_q  <= '0;
      commit_new_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values regardless of statement order.
      valid_q        <= valid_d;
      done_q         <= done_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_valid_q <= commit_valid_d;
      commit_addr_q  <= commit_addr_d;
      commit_lreg_q  <= commit_lreg_d;
      commit_new_q   <= commit_new_d;
    end
  end

  // Payload capture at the tail when an allocation fires.
  // NOTE: the payload storage has no reset. valid_q gates every read of it,
  // and leaving it unreset lets it map onto plain storage.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      uses_rw_mem[tail_q] <= alloc_uses_rw;
      logical_mem[tail_q] <= alloc_logical;
      prev_mem[tail_q]    <= alloc_prev_phys;
      new_mem[tail_q]     <= alloc_new_phys;
    end
  end

endmodule

// File: tb/tb_active_list.sv
// tb_active_list: directed self-checking bench for active_list. It uses a
// linear sequence of steps with hand-computed expected values. Inputs change
// 1 ns after each rising edge, and outputs are checked at that same point.
module tb_active_list;

  localparam int DEPTH  = 16;
  localparam int PREG_W = 6;
  localparam int LREG_W = 5;
  localparam int TAG_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              alloc_valid;
  logic              alloc_ready;
  logic              alloc_uses_rw;
  logic [LREG_W-1:0] alloc_logical;
  logic [PREG_W-1:0] alloc_prev_phys;
  logic [PREG_W-1:0] alloc_new_phys;
  logic [TAG_W-1:0]  alloc_tag;
  logic              wb_valid;
  logic [TAG_W-1:0]  wb_tag;
  logic              flush;
  logic              commit_valid;
  logic [PREG_W-1:0] commit_reg_addr;
  logic [LREG_W-1:0] commit_logical;
  logic [PREG_W-1:0] commit_new_phys;
  logic [TAG_W:0]    count;
  logic              empty;
  logic              full;

  int n_assert = 0;
  int n_fail   = 0;

  active_list #(
    .DEPTH (DEPTH),
    .PREG_W(PREG_W),
    .LREG_W(LREG_W),
    .TAG_W (TAG_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .alloc_valid    (alloc_valid),
    .alloc_ready    (alloc_ready),
    .alloc_uses_rw  (alloc_uses_rw),
    .alloc_logical  (alloc_logical),
    .alloc_prev_phys(alloc_prev_phys),
    .alloc_new_phys (alloc_new_phys),
    .alloc_tag      (alloc_tag),
    .wb_valid       (wb_valid),
    .wb_tag         (wb_tag),
    .flush          (flush),
    .commit_valid   (commit_valid),
    .commit_reg_addr(commit_reg_addr),
    .commit_logical (commit_logical),
    .commit_new_phys(commit_new_phys),
    .count          (count),
    .empty          (empty),
    .full           (full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alloc(input logic v, input logic rw, input int lg, input int pp, input int np);
    alloc_valid     = v;
    alloc_uses_rw   = rw;
    alloc_logical   = LREG_W'(lg);
    alloc_prev_phys = PREG_W'(pp);
    alloc_new_phys  = PREG_W'(np);
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    wb_valid = 1'b0;
    wb_tag   = '0;
    set_alloc(1'b0, 1'b0, 0, 0, 0);

    // Reset state
    #12;
    check("rst_ready", alloc_ready, 1);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_tag", alloc_tag, 0);
    check("rst_count", count, 0);
    check("rst_cv", commit_valid, 0);
    check("rst_addr", commit_reg_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    cycle();

    // Allocate three instructions
    for (int i = 0; i < 3; i++) begin
      check("alloc3_tag", alloc_tag, i);
      set_alloc(1'b1, 1'b1, i + 1, i + 1, 32 + i);
      cycle();
    end
    set_alloc(1'b0, 1'b0, 0, 0, 0);
    check("alloc3_count", count, 3);
    check("alloc3_cv", commit_valid, 0);

    // Out-of-order writebacks: tag 2 first, with no retire since the head is not done
    wb_valid = 1'b1; wb_tag = 4'd2;
    cycle();
    wb_valid = 1'b0;
    cycle();
    check("wb2_no_commit", commit_valid, 0);
    check("wb2_count", count, 3);
    // wb to tag 0: done becomes visible at this edge, and the retire happens on the next edge
    wb_valid = 1'b1; wb_tag = 4'd0;
    cycle();
    check("wb0_latency", commit_valid, 0);
    wb_tag = 4'd1;
    cycle();
    wb_valid = 1'b0;
    check("c0_cv", commit_valid, 1);
    check("c0_addr", commit_reg_addr, 1);
    check("c0_lreg", commit_logical, 1);
    check("c0_new", commit_new_phys, 32);
    check("c0_count", count, 2);
    cycle();
    check("c1_cv", commit_valid, 1);
    check("c1_addr", commit_reg_addr, 2);
    check("c1_count", count, 1);
    cycle();
    check("c2_cv", commit_valid, 1);
    check("c2_addr", commit_reg_addr, 3);
    check("c2_lreg", commit_logical, 3);
    check("c2_new", commit_new_phys, 34);
    check("c2_count", count, 0);
    check("c2_empty", empty, 1);
    cycle();
    check("idle_cv", commit_valid, 0);
    check("idle_addr_hold", commit_reg_addr, 3);

    // Flush the empty buffer so the pointers return to 0, then fill all 16 entries
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("flush0_tag", alloc_tag, 0);
    for (int i = 0; i < DEPTH; i++) begin
      check("fill_tag", alloc_tag, i);
      set_alloc(1'b1, 1'b1, i, 10 + i, 40 + i);
      cycle();
    end
    check("fill_full", full, 1);
    check("fill_ready", alloc_ready, 0);
    check("fill_count", count, 16);
    check("fill_tag_wrap", alloc_tag, 0);
    // 17th alloc attempt while full is ignored
    set_alloc(1'b1, 1'b1, 31, 63, 63);
    cycle();
    set_alloc(1'b0, 1'b0, 0, 0, 0);
    check("ovf_count", count, 16);
    check("ovf_tag", alloc_tag, 0);
    check("ovf_full", full, 1);
    // Write back all 16 entries, one per cycle; commits trail the writebacks by one cycle
    wb_valid = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      wb_tag = TAG_W'(k);
      cycle();
      if (k > 0) begin
        check("drain_cv", commit_valid, 1);
        check("drain_addr", commit_reg_addr, 10 + k - 1);
      end
    end
    wb_valid = 1'b0;
    cycle();
    check("drain15_cv", commit_valid, 1);
    check("drain15_addr", commit_reg_addr, 25);
    check("drain15_new", commit_new_phys, 55);
    check("drain_count", count, 0);
    check("drain_empty", empty, 1);
    check("wrap_tag", alloc_tag, 0);

    // An entry with uses_rw = 0 retires silently; the next entry commits normally
    set_alloc(1'b1, 1'b0, 4, 7, 45);
    cycle();
    set_alloc(1'b1, 1'b1, 9, 8, 50);
    cycle();
    set_alloc(1'b0, 1'b0, 0, 0, 0);
    check("norw_tag", alloc_tag, 2);
    wb_valid = 1'b1; wb_tag = 4'd0;
    cycle();
    check("norw_pre_cv", commit_valid, 0);
    wb_tag = 4'd1;
    cycle();
    wb_valid = 1'b0;
    check("norw_cv", commit_valid, 0);
    check("norw_addr", commit_reg_addr, 7);
    check("norw_lreg", commit_logical, 4);
    check("norw_count", count, 1);
    cycle();
    check("rw_cv", commit_valid, 1);
    check("rw_addr", commit_reg_addr, 8);
    check("rw_lreg", commit_logical, 9);
    check("rw_new", commit_new_phys, 50);
    check("rw_count", count, 0);

    // Five entries outstanding (tags 2..6); the head writes back, then a flush overrides retire, wb and alloc
    for (int i = 0; i < 5; i++) begin
      set_alloc(1'b1, 1'b1, i, 20 + i, 30 + i);
      cycle();
    end
    set_alloc(1'b0, 1'b0, 0, 0, 0);
    check("f5_count", count, 5);
    wb_valid = 1'b1; wb_tag = 4'd2;
    cycle();
    flush = 1'b1; wb_tag = 4'd3;
    set_alloc(1'b1, 1'b1, 1, 1, 1);
    cycle();
    flush = 1'b0; wb_valid = 1'b0;
    set_alloc(1'b0, 1'b0, 0, 0, 0);
    check("flush_count", count, 0);
    check("flush_empty", empty, 1);
    check("flush_cv", commit_valid, 0);
    check("flush_tag", alloc_tag, 0);
    check("flush_ready", alloc_ready, 1);
    cycle();
    check("flush_post_cv", commit_valid, 0);
    check("flush_post_count", count, 0);

    // Asynchronous reset while commit_valid is high
    set_alloc(1'b1, 1'b1, 7, 33, 60);
    cycle();
    set_alloc(1'b0, 1'b0, 0, 0, 0);
    wb_valid = 1'b1; wb_tag = 4'd0;
    cycle();
    wb_valid = 1'b0;
    cycle();
    check("pre_rst_cv", commit_valid, 1);
    check("pre_rst_addr", commit_reg_addr, 33);
    #2;
    rst = 1'b1;
    #1;
    check("arst_cv", commit_valid, 0);
    check("arst_addr", commit_reg_addr, 0);
    check("arst_lreg", commit_logical, 0);
    check("arst_new", commit_new_phys, 0);
    check("arst_count", count, 0);
    check("arst_empty", empty, 1);
    check("arst_tag", alloc_tag, 0);
    @(negedge clk);
    rst = 1'b0;
    cycle();
    check("post_rst_cv", commit_valid, 0);
    check("post_rst_count", count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
